// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usr_pkg;

  // Operation select, as presented on the mode port.
  typedef enum logic [2:0] {
    USR_HOLD = 3'b000,
    USR_LOAD = 3'b001,
    USR_SHL  = 3'b010,
    USR_SHR  = 3'b011,
    USR_ROL  = 3'b100,
    USR_ROR  = 3'b101,
    USR_CLR  = 3'b110,
    USR_INV  = 3'b111
  } usr_mode_t;

  // Counter must represent 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_cnt.sv
// Saturating shift counter with a one-cycle done pulse on reaching WIDTH.
// Latency: cnt_o/done_o are registered, updated on the edge that samples en_i.
// Backpressure: none; en_i low freezes the count and forces done low next cycle.
// Ports: clk, rst_n (async active-low), en_i, clr_i (zero the count),
//        inc_i (count one shift), cnt_o (count), done_o (pulse).
module usr_cnt
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          inc_i,
  output logic [cnt_width(WIDTH)-1:0]   cnt_o,
  output logic                          done_o
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          saturated;

  assign saturated = (cnt_q == CW'(WIDTH));

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i && !saturated) begin
        cnt_d = cnt_q + 1'b1;
        // Only the WIDTH-1 -> WIDTH transition fires; once saturated the
        // pulse stays quiet until a clear rearms the counter.
        done_d = (cnt_q == CW'(WIDTH - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear/invert, serial I/O both ends.
// Latency: 1 cycle for every mode; q_bar/sout_* are combinational from q only.
// Backpressure: none; en low holds all state (done drops after one cycle).
// Ports: clk, rst_n, en, mode[2:0], d, sin_l, sin_r -> q, q_bar, sout_l,
//        sout_r, shift_cnt (shifts since load/clear, saturating), done.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [2:0]                  mode,
  input  logic [WIDTH-1:0]            d,
  input  logic                        sin_l,
  input  logic                        sin_r,
  output logic [WIDTH-1:0]            q,
  output logic [WIDTH-1:0]            q_bar,
  output logic                        sout_l,
  output logic                        sout_r,
  output logic [cnt_width(WIDTH)-1:0] shift_cnt,
  output logic                        done
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_chk
    $error("univ_shift_reg: WIDTH must be in 2..64");
  end

  usr_mode_t        mode_e;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cnt_clr, cnt_inc;

  assign mode_e = usr_mode_t'(mode);

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_e)
        USR_HOLD: q_d = q_q;
        USR_LOAD: q_d = d;
        USR_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
        USR_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
        USR_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        USR_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        USR_CLR:  q_d = '0;
        USR_INV:  q_d = ~q_q;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // LOAD and CLR start a fresh word; any shift or rotate counts one bit moved.
  assign cnt_clr = (mode_e == USR_LOAD) || (mode_e == USR_CLR);
  assign cnt_inc = (mode_e == USR_SHL) || (mode_e == USR_SHR) ||
                   (mode_e == USR_ROL) || (mode_e == USR_ROR);

  usr_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (shift_cnt),
    .done_o (done)
  );

  assign q      = q_q;
  assign q_bar  = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule
